// File: rtl/reg_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_ctrl_pkg
// Description : Shared parameters for the register write-back path:
//               register-address and data widths, the register-file
//               write-enable encoding, and the source identifier used by
//               the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_write_ctrl_pkg;

  // Datapath widths of the register file write port.
  localparam int c_reg_addr_w = 5;
  localparam int c_data_w     = 32;

  // Register-file write-enable encoding.
  localparam logic c_we_active   = 1'b1;
  localparam logic c_we_inactive = 1'b0;

  // Which source queue was granted on the most recent pop.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // x0 is hard-wired to zero, so a write to it must never reach the file.
  function automatic logic we_encode(input logic [c_reg_addr_w-1:0] rd);
    return (rd != '0) ? c_we_active : c_we_inactive;
  endfunction

endpackage : reg_write_ctrl_pkg
`default_nettype wire

// File: rtl/reg_write_ctrl_wb.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Per-source write-back queue holding {rd, data} pairs.
//               Exposes every entry's rd and valid bit so the parent can
//               detect pending writes to a queried register.
// Ports       : clk, rst_n          clock, async active-low reset
//               push, push_rd/data  enqueue (ignored when full)
//               pop                 dequeue head (ignored when empty)
//               full, empty         occupancy flags
//               head_rd, head_data  oldest entry
//               entry_rd, entry_valid  per-slot rd and occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import reg_write_ctrl_pkg::*;
#(
  parameter int DEPTH = 2   // power of two, at least 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push,
  input  logic [c_reg_addr_w-1:0]               push_rd,
  input  logic [c_data_w-1:0]                   push_data,
  input  logic                                  pop,
  output logic                                  full,
  output logic                                  empty,
  output logic [c_reg_addr_w-1:0]               head_rd,
  output logic [c_data_w-1:0]                   head_data,
  output logic [DEPTH-1:0][c_reg_addr_w-1:0]    entry_rd,
  output logic [DEPTH-1:0]                      entry_valid
);

  localparam int c_ptr_w = $clog2(DEPTH);
  // One extra bit so a full queue is distinguishable from an empty one.
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [DEPTH-1:0][c_reg_addr_w-1:0] r_rd;
  logic [DEPTH-1:0][c_data_w-1:0]     r_data;
  logic [c_ptr_w-1:0]                 r_wr_ptr;
  logic [c_ptr_w-1:0]                 r_rd_ptr;
  logic [c_cnt_w-1:0]                 r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  assign head_rd   = r_rd[r_rd_ptr];
  assign head_data = r_data[r_rd_ptr];
  assign entry_rd  = r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd     <= '0;
      r_data   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_rd[r_wr_ptr]   <= push_rd;
        r_data[r_wr_ptr] <= push_data;
        // Depth is a power of two, so the natural pointer overflow wraps.
        r_wr_ptr         <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is occupied when its distance from the read pointer is below
  // the current occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_valid
    logic [c_ptr_w-1:0] w_off;
    assign w_off          = c_ptr_w'(i) - r_rd_ptr;
    assign entry_valid[i] = ({1'b0, w_off} < r_count);
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/reg_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_ctrl
// Description : Merges ALU and load-unit results into the single register
//               file write port. Each source has its own queue; a
//               round-robin arbiter pops at most one head per cycle into
//               the registered write port. Hazard queries report whether a
//               register still has a write pending.
// Ports       : clk, rst_n                    clock, async active-low reset
//               alu_valid/rd/data, alu_ready  ALU result handshake
//               lsu_valid/rd/data, lsu_ready  load-unit result handshake
//               we, wr, wd                    registered write port
//               q_rs1, q_rs2                  hazard query addresses
//               rs1_busy, rs2_busy            pending-write indication
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_ctrl
  import reg_write_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 2   // power of two, at least 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [c_reg_addr_w-1:0]   alu_rd,
  input  logic [c_data_w-1:0]       alu_data,
  output logic                      alu_ready,
  input  logic                      lsu_valid,
  input  logic [c_reg_addr_w-1:0]   lsu_rd,
  input  logic [c_data_w-1:0]       lsu_data,
  output logic                      lsu_ready,
  output logic                      we,
  output logic [c_reg_addr_w-1:0]   wr,
  output logic [c_data_w-1:0]       wd,
  input  logic [c_reg_addr_w-1:0]   q_rs1,
  input  logic [c_reg_addr_w-1:0]   q_rs2,
  output logic                      rs1_busy,
  output logic                      rs2_busy
);

  // ---------------------------------------------------------------- queues
  logic                                    w_alu_full, w_alu_empty;
  logic                                    w_lsu_full, w_lsu_empty;
  logic [c_reg_addr_w-1:0]                 w_alu_head_rd, w_lsu_head_rd;
  logic [c_data_w-1:0]                     w_alu_head_data, w_lsu_head_data;
  logic [FIFO_DEPTH-1:0][c_reg_addr_w-1:0] w_alu_entry_rd, w_lsu_entry_rd;
  logic [FIFO_DEPTH-1:0]                   w_alu_entry_valid, w_lsu_entry_valid;

  logic w_alu_push, w_lsu_push;
  logic w_grant_alu, w_grant_lsu, w_pop_any;

  // Ready depends only on occupancy, never on valid or a same-cycle pop.
  assign alu_ready  = ~w_alu_full;
  assign lsu_ready  = ~w_lsu_full;
  assign w_alu_push = alu_valid & alu_ready;
  assign w_lsu_push = lsu_valid & lsu_ready;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (w_alu_push),
    .push_rd     (alu_rd),
    .push_data   (alu_data),
    .pop         (w_grant_alu),
    .full        (w_alu_full),
    .empty       (w_alu_empty),
    .head_rd     (w_alu_head_rd),
    .head_data   (w_alu_head_data),
    .entry_rd    (w_alu_entry_rd),
    .entry_valid (w_alu_entry_valid)
  );

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (w_lsu_push),
    .push_rd     (lsu_rd),
    .push_data   (lsu_data),
    .pop         (w_grant_lsu),
    .full        (w_lsu_full),
    .empty       (w_lsu_empty),
    .head_rd     (w_lsu_head_rd),
    .head_data   (w_lsu_head_data),
    .entry_rd    (w_lsu_entry_rd),
    .entry_valid (w_lsu_entry_valid)
  );

  // -------------------------------------------------------------- arbiter
  src_e r_last_grant;

  // ALU wins when it is the only requester, or on a tie when the LSU was
  // served last. The LSU takes every remaining non-empty cycle.
  assign w_grant_alu = ~w_alu_empty &
                       (w_lsu_empty | (r_last_grant == SRC_LSU));
  assign w_grant_lsu = ~w_lsu_empty & ~w_grant_alu;
  assign w_pop_any   = w_grant_alu | w_grant_lsu;

  logic [c_reg_addr_w-1:0] w_sel_rd;
  logic [c_data_w-1:0]     w_sel_data;

  assign w_sel_rd   = w_grant_alu ? w_alu_head_rd   : w_lsu_head_rd;
  assign w_sel_data = w_grant_alu ? w_alu_head_data : w_lsu_head_data;

  // -------------------------------------------------------- output register
  logic                    r_we;
  logic [c_reg_addr_w-1:0] r_wr;
  logic [c_data_w-1:0]     r_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we         <= c_we_inactive;
      r_wr         <= '0;
      r_wd         <= '0;
      r_last_grant <= SRC_LSU;
    end else begin
      r_we <= c_we_inactive;
      if (w_pop_any) begin
        // x0 results are consumed here but never enabled on the port.
        r_we         <= we_encode(w_sel_rd);
        r_wr         <= w_sel_rd;
        r_wd         <= w_sel_data;
        r_last_grant <= w_grant_alu ? SRC_ALU : SRC_LSU;
      end
    end
  end

  assign we = r_we;
  assign wr = r_wr;
  assign wd = r_wd;

  // ---------------------------------------------------------- hazard query
  // A register is busy while any queued entry targets it or while the
  // write port is currently writing it. x0 is never busy.
  logic w_rs1_hit, w_rs2_hit;

  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_alu_entry_valid[i] && (w_alu_entry_rd[i] == q_rs1)) w_rs1_hit = 1'b1;
      if (w_lsu_entry_valid[i] && (w_lsu_entry_rd[i] == q_rs1)) w_rs1_hit = 1'b1;
      if (w_alu_entry_valid[i] && (w_alu_entry_rd[i] == q_rs2)) w_rs2_hit = 1'b1;
      if (w_lsu_entry_valid[i] && (w_lsu_entry_rd[i] == q_rs2)) w_rs2_hit = 1'b1;
    end
    if ((r_we == c_we_active) && (r_wr == q_rs1)) w_rs1_hit = 1'b1;
    if ((r_we == c_we_active) && (r_wr == q_rs2)) w_rs2_hit = 1'b1;
  end

  assign rs1_busy = (q_rs1 != '0) & w_rs1_hit;
  assign rs2_busy = (q_rs2 != '0) & w_rs2_hit;

endmodule : reg_write_ctrl
`default_nettype wire

// File: tb/tb_reg_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_ctrl
// Description : Directed self-checking bench for reg_write_ctrl with
//               hand-computed expected write-port sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_ctrl;

  typedef logic [36:0] wr_t;   // {rd, data}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wd;
  logic [4:0]  q_rs1 = '0;
  logic [4:0]  q_rs2 = '0;
  logic        rs1_busy;
  logic        rs2_busy;

  int n_checks = 0;
  int n_bad    = 0;

  wr_t wlog[$];
  wr_t exp_log[$];

  reg_write_ctrl #(
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .we        (we),
    .wr        (wr),
    .wd        (wd),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

  always #5 clk = ~clk;

  // Record every enabled write, sampled away from the active edge.
  always @(negedge clk) begin
    if (we === 1'b1) wlog.push_back({wr, wd});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 64'(wlog.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      wr_t got;
      got = (i < wlog.size()) ? wlog[i] : 'x;
      chk(tag, 64'(got), 64'(exp_log[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic offer_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_valid = v; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic do_reset();
    offer_alu(1'b0, 5'd0, 32'd0);
    offer_lsu(1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wlog.delete();
  endtask

  initial begin
    // ---------------------------------------------------- reset state
    q_rs1 = 5'd3; q_rs2 = 5'd4;
    step();
    chk("rst_we", we, 1'b0);
    chk("rst_wr", wr, 5'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_lsu_ready", lsu_ready, 1'b1);
    chk("rst_rs1_busy", rs1_busy, 1'b0);
    chk("rst_rs2_busy", rs2_busy, 1'b0);

    // ------------------------------------------------ single ALU write
    do_reset();
    q_rs1 = 5'd5; q_rs2 = 5'd6;
    offer_alu(1'b1, 5'd5, 32'h1234_5678);
    step();                                   // accepted
    offer_alu(1'b0, 5'd0, 32'd0);
    chk("single_we_e0", we, 1'b0);
    chk("single_busy_e0", rs1_busy, 1'b1);
    chk("single_busy2_e0", rs2_busy, 1'b0);
    step();                                   // popped into output
    chk("single_we_e1", we, 1'b1);
    chk("single_wr_e1", wr, 5'd5);
    chk("single_wd_e1", wd, 32'h1234_5678);
    chk("single_busy_e1", rs1_busy, 1'b1);
    step();
    chk("single_we_e2", we, 1'b0);
    chk("single_busy_e2", rs1_busy, 1'b0);

    // ------------------------------------------------------------ tie
    // Two back-to-back tie offers: ALU wins the first tie after reset,
    // then the next tie goes to the LSU.
    do_reset();
    offer_alu(1'b1, 5'd1, 32'hA);
    offer_lsu(1'b1, 5'd2, 32'hB);
    step();
    offer_alu(1'b1, 5'd3, 32'hC);
    offer_lsu(1'b1, 5'd4, 32'hD);
    step();
    offer_alu(1'b0, 5'd0, 32'd0);
    offer_lsu(1'b0, 5'd0, 32'd0);
    chk("tie_we_1", we, 1'b1);
    chk("tie_wr_1", wr, 5'd1);
    chk("tie_wd_1", wd, 32'hA);
    chk("tie_lsu_full", lsu_ready, 1'b0);
    step();
    chk("tie_wr_2", wr, 5'd2);
    chk("tie_wd_2", wd, 32'hB);
    step();
    chk("tie_wr_3", wr, 5'd3);
    step();
    chk("tie_wr_4", wr, 5'd4);
    chk("tie_we_4", we, 1'b1);
    step();
    chk("tie_we_idle", we, 1'b0);

    // --------------------------------------------------------- x0 drop
    do_reset();
    q_rs1 = 5'd0;
    offer_lsu(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    offer_lsu(1'b0, 5'd0, 32'd0);
    chk("x0_busy_e0", rs1_busy, 1'b0);
    step();
    chk("x0_we_e1", we, 1'b0);
    chk("x0_wd_e1", wd, 32'hFFFF_FFFF);
    chk("x0_busy_e1", rs1_busy, 1'b0);
    step();
    chk("x0_lsu_ready", lsu_ready, 1'b1);
    chk("x0_log", 64'(wlog.size()), 64'd0);

    // ------------------------------------------------- backpressure
    // A0 first makes the ALU the last grant, so the LSU wins the ties
    // and the ALU queue fills.
    do_reset();
    offer_alu(1'b1, 5'd7, 32'hA0);
    step();
    offer_alu(1'b1, 5'd11, 32'hA1);
    offer_lsu(1'b1, 5'd21, 32'hB1);
    step();
    offer_alu(1'b1, 5'd12, 32'hA2);
    offer_lsu(1'b1, 5'd22, 32'hB2);
    step();
    chk("bp_alu_full", alu_ready, 1'b0);
    chk("bp_lsu_ready", lsu_ready, 1'b1);
    offer_alu(1'b1, 5'd13, 32'hA3);
    offer_lsu(1'b0, 5'd0, 32'd0);
    step();                                   // A3 held
    chk("bp_alu_reopen", alu_ready, 1'b1);
    step();                                   // A3 accepted
    offer_alu(1'b0, 5'd0, 32'd0);
    chk("bp_alu_full2", alu_ready, 1'b0);
    repeat (4) step();
    exp_log.delete();
    exp_log.push_back({5'd7,  32'hA0});
    exp_log.push_back({5'd21, 32'hB1});
    exp_log.push_back({5'd11, 32'hA1});
    exp_log.push_back({5'd22, 32'hB2});
    exp_log.push_back({5'd12, 32'hA2});
    exp_log.push_back({5'd13, 32'hA3});
    check_log("bp_seq");

    // ------------------------------------------------ reset mid-stream
    do_reset();
    offer_alu(1'b1, 5'd15, 32'hF15);
    offer_lsu(1'b1, 5'd16, 32'hF16);
    step();
    step();
    offer_alu(1'b0, 5'd0, 32'd0);
    offer_lsu(1'b0, 5'd0, 32'd0);
    q_rs1 = 5'd16; q_rs2 = 5'd15;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_we", we, 1'b0);
    chk("mid_wr", wr, 5'd0);
    chk("mid_alu_ready", alu_ready, 1'b1);
    chk("mid_lsu_ready", lsu_ready, 1'b1);
    chk("mid_rs1_busy", rs1_busy, 1'b0);
    chk("mid_rs2_busy", rs2_busy, 1'b0);
    step();
    rst_n = 1'b1;
    wlog.delete();
    repeat (10) step();
    chk("mid_no_stale", 64'(wlog.size()), 64'd0);

    // ------------------------------------- push onto a popping queue
    do_reset();
    q_rs1 = 5'd8; q_rs2 = 5'd9;
    offer_alu(1'b1, 5'd8, 32'h80);
    step();
    offer_alu(1'b1, 5'd9, 32'h90);
    step();                                   // pop 8, push 9
    offer_alu(1'b0, 5'd0, 32'd0);
    chk("pp_wr_1", wr, 5'd8);
    chk("pp_alu_ready", alu_ready, 1'b1);
    chk("pp_busy_9", rs2_busy, 1'b1);
    step();
    chk("pp_wr_2", wr, 5'd9);
    chk("pp_wd_2", wd, 32'h90);
    chk("pp_busy_8", rs1_busy, 1'b0);
    step();
    chk("pp_we_idle", we, 1'b0);
    chk("pp_busy_9_end", rs2_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule : tb_reg_write_ctrl
`default_nettype wire
